// File: rtl/led_strip_scheduler.sv
// WS2812 strip scheduler: fetches each pixel colour from the mixer, serialises it GRB/MSB-first,
// then holds the line low for the latch/reset gap. Optional LED_BRIGHTNESS_EN adds brilho scaling.
module led_strip_scheduler #(
  parameter int unsigned N        = 10,
  parameter int unsigned NUM_LEDS = 60,
  parameter int unsigned T0H_CYC  = 20,
  parameter int unsigned T1H_CYC  = 40,
  parameter int unsigned TBIT_CYC = 63,
  parameter int unsigned TRST_CYC = 3000
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] nivel,
`ifdef LED_BRIGHTNESS_EN
  input  logic [2:0]   brilho,
`endif
  input  logic [23:0]  cor_led,
  output logic [N-1:0] led_idx,
  output logic         dout,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CntMax = (TBIT_CYC > TRST_CYC) ? TBIT_CYC : TRST_CYC;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StBit,
    StGap,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  i_q, i_d;
  logic [N-1:0]  nivel_q, nivel_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [23:0]   pix_q, pix_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;
  logic [7:0]    ch_r, ch_g, ch_b;

`ifdef LED_BRIGHTNESS_EN
  logic [2:0] brilho_q, brilho_d;

  assign ch_r = cor_led[23:16] >> brilho_q;
  assign ch_g = cor_led[15:8]  >> brilho_q;
  assign ch_b = cor_led[7:0]   >> brilho_q;
`else
  assign ch_r = cor_led[23:16];
  assign ch_g = cor_led[15:8];
  assign ch_b = cor_led[7:0];
`endif

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    nivel_d  = nivel_q;
    idx_d    = idx_q;
    pix_d    = pix_q;
    bitcnt_d = bitcnt_q;
    cnt_d    = cnt_q;
`ifdef LED_BRIGHTNESS_EN
    brilho_d = brilho_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          nivel_d = nivel;
          i_d     = '0;
          idx_d   = '0;
`ifdef LED_BRIGHTNESS_EN
          brilho_d = brilho;
`endif
          state_d = StFetch;
        end
      end
      StFetch: begin
        state_d = StCapture;
      end
      StCapture: begin
        pix_d    = (i_q <= nivel_q) ? {ch_g, ch_r, ch_b} : 24'h000000;
        bitcnt_d = 5'd23;
        cnt_d    = '0;
        state_d  = StBit;
      end
      StBit: begin
        if (cnt_q == CW'(TBIT_CYC - 1)) begin
          cnt_d = '0;
          if (bitcnt_q == 5'd0) begin
            if (i_q == N'(NUM_LEDS - 1)) begin
              state_d = StGap;
            end else begin
              i_d     = i_q + N'(1);
              idx_d   = i_q + N'(1);
              state_d = StFetch;
            end
          end else begin
            bitcnt_d = bitcnt_q - 5'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CW'(TRST_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // dout is registered from next-state values so the serial line never glitches.
    dout_d = (state_d == StBit) &&
             (cnt_d < (pix_d[bitcnt_d] ? CW'(T1H_CYC) : CW'(T0H_CYC)));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      i_q      <= '0;
      nivel_q  <= '0;
      idx_q    <= '0;
      pix_q    <= '0;
      bitcnt_q <= '0;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
`ifdef LED_BRIGHTNESS_EN
      brilho_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      nivel_q  <= nivel_d;
      idx_q    <= idx_d;
      pix_q    <= pix_d;
      bitcnt_q <= bitcnt_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
`ifdef LED_BRIGHTNESS_EN
      brilho_q <= brilho_d;
`endif
    end
  end

  assign led_idx = idx_q;
  assign dout    = dout_q;
  assign busy    = (state_q == StFetch) || (state_q == StCapture) ||
                   (state_q == StBit)   || (state_q == StGap);
  assign done    = (state_q == StDone);

endmodule
